// File: rtl/eth_phy_10g_pkg.sv
// Shared 10G PHY definitions: gearbox period constants, sync header codes and the 66-bit block type.
package eth_phy_10g_pkg;

  localparam int unsigned GBX_SEQ_LEN = 33;
  localparam int unsigned GBX_BLOCKS  = 32;

  localparam int unsigned BLK_DATA_W = 64;
  localparam int unsigned BLK_HDR_W  = 2;
  localparam int unsigned BLK_W      = BLK_DATA_W + BLK_HDR_W;
  localparam int unsigned COMB_W     = BLK_DATA_W + BLK_W;
  localparam int unsigned SEQ_W      = 6;
  localparam int unsigned LEN_W      = 7;

  localparam logic [BLK_HDR_W-1:0] SYNC_DATA = 2'b10;
  localparam logic [BLK_HDR_W-1:0] SYNC_CTRL = 2'b01;

  // Header in the LSBs so it leaves the gearbox first.
  typedef struct packed {
    logic [BLK_DATA_W-1:0] data;
    logic [BLK_HDR_W-1:0]  hdr;
  } blk66_t;

endpackage

// File: rtl/eth_phy_10g_gbx_align.sv
// Combinational 130-bit merge of the residual bits with a new 66-bit block.
module eth_phy_10g_gbx_align
  import eth_phy_10g_pkg::*;
(
  input  logic [BLK_W-1:0]      res_bits,
  input  logic [LEN_W-1:0]      res_len,
  input  blk66_t                blk,
  output logic [BLK_W-1:0]      next_res,
  output logic [BLK_DATA_W-1:0] out_word
);

  logic [COMB_W-1:0] combined;

  // New block lands directly above the residual bits already waiting.
  always_comb begin
    combined = COMB_W'(res_bits) | (COMB_W'(blk) << res_len);
  end

  assign out_word = combined[BLK_DATA_W-1:0];
  assign next_res = combined[COMB_W-1:BLK_DATA_W];

endmodule

// File: rtl/eth_phy_10g_tx_gbx.sv
// 66b->64b TX gearbox: 32 blocks per 33 output words, one upstream stall per period.
// Optional header checker enabled by defining ETH_PHY_10G_TX_GBX_HDR_CHECK_EN.
module eth_phy_10g_tx_gbx
  import eth_phy_10g_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int HDR_WIDTH  = 2
) (
  input  logic                  tx_clk,
  input  logic                  tx_rst,
  input  logic [DATA_WIDTH-1:0] serdes_tx_data,
  input  logic [HDR_WIDTH-1:0]  serdes_tx_hdr,
  output logic                  serdes_tx_ready,
  output logic [DATA_WIDTH-1:0] gbx_tx_data,
  output logic                  gbx_tx_sync,
  output logic                  gbx_tx_hdr_err
);

  localparam logic [SEQ_W-1:0] STALL_SEQ = SEQ_W'(GBX_BLOCKS);

  logic [SEQ_W-1:0]      seq_q;
  logic [BLK_W-1:0]      res_q;
  logic [BLK_W-1:0]      next_res;
  logic [BLK_DATA_W-1:0] out_word;
  logic [LEN_W-1:0]      res_len;
  logic                  stall;
  blk66_t                blk;

  assign stall           = (seq_q == STALL_SEQ);
  assign serdes_tx_ready = ~stall;
  assign res_len         = {seq_q, 1'b0};
  assign blk             = '{data: serdes_tx_data, hdr: serdes_tx_hdr};

  eth_phy_10g_gbx_align u_align (
    .res_bits (res_q),
    .res_len  (res_len),
    .blk      (blk),
    .next_res (next_res),
    .out_word (out_word)
  );

  // Stall slot drains the exactly-full residual without consuming input.
  always_ff @(posedge tx_clk) begin
    if (tx_rst) begin
      seq_q       <= '0;
      res_q       <= '0;
      gbx_tx_data <= '0;
      gbx_tx_sync <= 1'b0;
    end else if (stall) begin
      seq_q       <= '0;
      res_q       <= '0;
      gbx_tx_data <= res_q[BLK_DATA_W-1:0];
      gbx_tx_sync <= 1'b0;
    end else begin
      seq_q       <= seq_q + SEQ_W'(1);
      res_q       <= next_res;
      gbx_tx_data <= out_word;
      gbx_tx_sync <= (seq_q == '0);
    end
  end

`ifdef ETH_PHY_10G_TX_GBX_HDR_CHECK_EN
  // Only 01 and 10 are legal sync headers.
  always_ff @(posedge tx_clk) begin
    if (tx_rst || stall) begin
      gbx_tx_hdr_err <= 1'b0;
    end else begin
      gbx_tx_hdr_err <= ~((serdes_tx_hdr == SYNC_DATA) || (serdes_tx_hdr == SYNC_CTRL));
    end
  end
`else
  assign gbx_tx_hdr_err = 1'b0;
`endif

endmodule

// File: tb/tb_eth_phy_10g_tx_gbx.sv
// Bench for eth_phy_10g_tx_gbx: bit-queue reference model plus directed literal checks.
module tb_eth_phy_10g_tx_gbx;

`ifdef ETH_PHY_10G_TX_GBX_HDR_CHECK_EN
  localparam bit HDR_CHK = 1'b1;
`else
  localparam bit HDR_CHK = 1'b0;
`endif

  logic        tx_clk = 1'b0;
  logic        tx_rst;
  logic [63:0] serdes_tx_data;
  logic [1:0]  serdes_tx_hdr;
  logic        serdes_tx_ready;
  logic [63:0] gbx_tx_data;
  logic        gbx_tx_sync;
  logic        gbx_tx_hdr_err;

  int checks = 0;
  int errors = 0;

  eth_phy_10g_tx_gbx dut (
    .tx_clk          (tx_clk),
    .tx_rst          (tx_rst),
    .serdes_tx_data  (serdes_tx_data),
    .serdes_tx_hdr   (serdes_tx_hdr),
    .serdes_tx_ready (serdes_tx_ready),
    .gbx_tx_data     (gbx_tx_data),
    .gbx_tx_sync     (gbx_tx_sync),
    .gbx_tx_hdr_err  (gbx_tx_hdr_err)
  );

  always #5 tx_clk = ~tx_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a serial bit queue; each cycle an accepted block appends
  // 66 bits LSB first and one 64-bit word is removed from the front.
  logic        bitq[$];
  int          mk = 0;
  bit          model_valid = 1'b0;
  logic [63:0] exp_data;
  logic        exp_sync, exp_err, exp_ready;
  logic [65:0] mblk;

  initial exp_ready = 1'b1;

  always @(posedge tx_clk) begin
    if (tx_rst) begin
      bitq.delete();
      mk       = 0;
      exp_data = '0;
      exp_sync = 1'b0;
      exp_err  = 1'b0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      if (mk != 32) begin
        mblk = {serdes_tx_data, serdes_tx_hdr};
        for (int i = 0; i < 66; i++) bitq.push_back(mblk[i]);
        exp_sync = (mk == 0);
        exp_err  = HDR_CHK && (serdes_tx_hdr == 2'b00 || serdes_tx_hdr == 2'b11);
      end else begin
        exp_sync = 1'b0;
        exp_err  = 1'b0;
      end
      for (int i = 0; i < 64; i++) exp_data[i] = (bitq.size() > 0) ? bitq.pop_front() : 1'b0;
      mk = (mk == 32) ? 0 : mk + 1;
    end
    exp_ready = (mk != 32);
  end

  // Per-cycle comparison, sampled on the falling edge.
  always @(negedge tx_clk) begin
    if (model_valid) begin
      chk("model_data", gbx_tx_data, exp_data);
      chk("model_sync", 64'(gbx_tx_sync), 64'(exp_sync));
      chk("model_err", 64'(gbx_tx_hdr_err), 64'(exp_err));
      chk("model_ready", 64'(serdes_tx_ready), 64'(exp_ready));
    end
  end

  bit prev_rdy = 1'b1;

  task automatic new_blk();
    serdes_tx_data = {$urandom, $urandom};
    serdes_tx_hdr  = 2'($urandom_range(0, 3));
  endtask

  // One cycle of a ready-honouring source: new block only after the last was taken.
  task automatic rand_cycle();
    @(negedge tx_clk);
    if (prev_rdy) new_blk();
    prev_rdy = serdes_tx_ready;
  endtask

  int          lows, syncs;
  bit          found;
  logic [63:0] d;
  logic [1:0]  h;

  initial begin
    tx_rst = 1'b1;
    serdes_tx_data = '0;
    serdes_tx_hdr  = '0;
    repeat (3) @(posedge tx_clk);
    @(negedge tx_clk);
    chk("rst_data", gbx_tx_data, 64'h0);
    chk("rst_sync", 64'(gbx_tx_sync), 64'h0);
    chk("rst_err", 64'(gbx_tx_hdr_err), 64'h0);
    chk("rst_ready", 64'(serdes_tx_ready), 64'h1);

    // First block after reset.
    tx_rst = 1'b0;
    serdes_tx_data = 64'h0FA58D310FA58D31;
    serdes_tx_hdr  = 2'b10;
    @(negedge tx_clk);
    chk("first_data", gbx_tx_data, 64'h3E9634C43E9634C6);
    chk("first_sync", 64'(gbx_tx_sync), 64'h1);
    prev_rdy = serdes_tx_ready;

    // Stall cadence over 330 cycles.
    lows = 0;
    syncs = 0;
    for (int i = 0; i < 330; i++) begin
      rand_cycle();
      if (!serdes_tx_ready) lows++;
      if (gbx_tx_sync) syncs++;
    end
    chk("cadence_ready_lows", 64'(lows), 64'd10);
    chk("cadence_syncs", 64'(syncs), 64'd10);

    // Backpressure: value changed during the stall is ignored.
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      rand_cycle();
      if (!serdes_tx_ready) found = 1'b1;
    end
    chk("bp_stall_seen", 64'(found), 64'h1);
    new_blk();
    @(negedge tx_clk);
    chk("bp_ready_back", 64'(serdes_tx_ready), 64'h1);
    new_blk();
    d = serdes_tx_data;
    h = serdes_tx_hdr;
    @(negedge tx_clk);
    chk("bp_accepted_word", gbx_tx_data, {d[61:0], h});
    chk("bp_sync", 64'(gbx_tx_sync), 64'h1);
    prev_rdy = 1'b1;

    // Reset mid-period at seq 17.
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      rand_cycle();
      if (gbx_tx_sync) found = 1'b1;
    end
    chk("mid_sync_seen", 64'(found), 64'h1);
    for (int i = 1; i < 16; i++) begin
      @(negedge tx_clk);
      new_blk();
    end
    @(negedge tx_clk);
    tx_rst = 1'b1;
    new_blk();
    @(negedge tx_clk);
    chk("mid_rst_data", gbx_tx_data, 64'h0);
    chk("mid_rst_sync", 64'(gbx_tx_sync), 64'h0);
    chk("mid_rst_ready", 64'(serdes_tx_ready), 64'h1);
    tx_rst = 1'b0;
    new_blk();
    d = serdes_tx_data;
    h = serdes_tx_hdr;
    @(negedge tx_clk);
    chk("mid_unshifted", gbx_tx_data, {d[61:0], h});
    chk("mid_post_sync", 64'(gbx_tx_sync), 64'h1);

    // Header checker: 11 then 01.
    serdes_tx_data = {$urandom, $urandom};
    serdes_tx_hdr  = 2'b11;
    @(negedge tx_clk);
    chk("hdr_err_11", 64'(gbx_tx_hdr_err), 64'(HDR_CHK));
    serdes_tx_hdr  = 2'b01;
    @(negedge tx_clk);
    chk("hdr_err_01", 64'(gbx_tx_hdr_err), 64'h0);
    prev_rdy = serdes_tx_ready;

    // Random tail with one stray reset pulse.
    for (int i = 0; i < 200; i++) begin
      rand_cycle();
      if (i == 90) tx_rst = 1'b1;
      if (i == 91) tx_rst = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
